// File: rtl/comma_word_aligner.sv
// comma_word_aligner: receive-side K28.5 word aligner feeding the 8b/10b decoder.
// Builds a 20-bit window from the last two deserializer words, searches all ten
// bit offsets for a comma, locks after LOCK_CNT commas at one offset and drops
// lock after UNLOCK_CNT commas seen only at other offsets.
// Optional feature macro: ALIGN_STATS_EN adds the relock_cnt statistics output.

// One search lane: flags a comma (either running disparity) in its candidate.
module comma_match_lane #(
  parameter logic [9:0] COMMA_N = 10'b0011111010,
  parameter logic [9:0] COMMA_P = 10'b1100000101
) (
  input  logic [9:0] cand,
  output logic       hit
);
  assign hit = (cand == COMMA_N) || (cand == COMMA_P);
endmodule

module comma_word_aligner #(
  parameter int         LOCK_CNT   = 3,
  parameter int         UNLOCK_CNT = 4,
  parameter logic [9:0] COMMA_N    = 10'b0011111010,
  parameter logic [9:0] COMMA_P    = 10'b1100000101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  rx_word,
  input  logic        rx_valid,
  output logic [9:0]  aligned_word,
  output logic        aligned_valid,
  output logic        is_comma,
  output logic        locked,
  output logic [3:0]  offset
`ifdef ALIGN_STATS_EN
  ,
  output logic [15:0] relock_cnt
`endif
);

  localparam int NUM_OFS = 10;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] cur_q, cur_d;
  logic [3:0] offset_q, offset_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic [9:0] aligned_word_q, aligned_word_d;
  logic       aligned_valid_q, aligned_valid_d;
  logic       is_comma_q, is_comma_d;
`ifdef ALIGN_STATS_EN
  logic [15:0] relock_q, relock_d;
`endif

  // The window as it stands after this beat: the stored word becomes the
  // older half and the incoming word the newer half, so no separate prev
  // register is needed.
  logic [19:0]                      win;
  logic [NUM_OFS-1:0][9:0]          cand;
  logic [NUM_OFS-1:0]               match;
  logic                             any_hit;
  logic [3:0]                       first_k;
  logic                             hit_cur;
  logic [3:0]                       cnt_inc;
  logic [3:0]                       err_inc;
  logic                             unused_win_lsb;

  assign win = {cur_q, rx_word};

  // An offset of 10 would be offset 0 of the next beat, so the newest
  // word's lsb never needs to be looked at on its own.
  assign unused_win_lsb = win[0];

  // One lane per candidate bit offset; candidate k starts k bits into the window.
  for (genvar k = 0; k < NUM_OFS; k++) begin : g_lane
    assign cand[k] = win[19-k -: 10];
    comma_match_lane #(
      .COMMA_N (COMMA_N),
      .COMMA_P (COMMA_P)
    ) u_lane (
      .cand (cand[k]),
      .hit  (match[k])
    );
  end

  // Priority pick of the lowest matching offset.
  always_comb begin
    any_hit = |match;
    first_k = 4'd0;
    for (int k = NUM_OFS - 1; k >= 0; k--) begin
      if (match[k]) first_k = 4'(k);
    end
  end

  assign hit_cur = match[offset_q];
  assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  assign err_inc = (err_q == 4'hF) ? err_q : err_q + 4'd1;

  // Next-state, counter and output computation; everything holds without rx_valid.
  always_comb begin
    state_d         = state_q;
    cur_d           = cur_q;
    offset_d        = offset_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
    aligned_word_d  = aligned_word_q;
    aligned_valid_d = 1'b0;
    is_comma_d      = is_comma_q;
`ifdef ALIGN_STATS_EN
    relock_d        = relock_q;
`endif
    if (rx_valid) begin
      cur_d = rx_word;
      // Emission uses the state and offset in force before this beat, so the
      // beat that drops lock still delivers its old-offset symbol.
      if (state_q == LOCKED) begin
        aligned_word_d  = cand[offset_q];
        aligned_valid_d = 1'b1;
        is_comma_d      = hit_cur;
      end
      unique case (state_q)
        HUNT: begin
          if (any_hit) begin
            offset_d = first_k;
            cnt_d    = 4'd1;
            if (LOCK_CNT == 1) begin
              state_d = LOCKED;
              err_d   = 4'd0;
            end else begin
              state_d = VERIFY;
            end
          end
        end
        VERIFY: begin
          if (hit_cur) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= 4'(LOCK_CNT)) begin
              state_d = LOCKED;
              err_d   = 4'd0;
            end
          end else if (any_hit) begin
            offset_d = first_k;
            cnt_d    = 4'd1;
          end
        end
        LOCKED: begin
          if (hit_cur) begin
            err_d = 4'd0;
          end else if (any_hit) begin
            err_d = err_inc;
            if (err_inc >= 4'(UNLOCK_CNT)) begin
              state_d = HUNT;
              cnt_d   = 4'd0;
              err_d   = 4'd0;
`ifdef ALIGN_STATS_EN
              if (relock_q != 16'hFFFF) relock_d = relock_q + 16'd1;
`endif
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // FSM state, window, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= HUNT;
      cur_q           <= 10'd0;
      offset_q        <= 4'd0;
      cnt_q           <= 4'd0;
      err_q           <= 4'd0;
      aligned_word_q  <= 10'd0;
      aligned_valid_q <= 1'b0;
      is_comma_q      <= 1'b0;
`ifdef ALIGN_STATS_EN
      relock_q        <= 16'd0;
`endif
    end else begin
      state_q         <= state_d;
      cur_q           <= cur_d;
      offset_q        <= offset_d;
      cnt_q           <= cnt_d;
      err_q           <= err_d;
      aligned_word_q  <= aligned_word_d;
      aligned_valid_q <= aligned_valid_d;
      is_comma_q      <= is_comma_d;
`ifdef ALIGN_STATS_EN
      relock_q        <= relock_d;
`endif
    end
  end

  assign aligned_word  = aligned_word_q;
  assign aligned_valid = aligned_valid_q;
  assign is_comma      = is_comma_q;
  assign locked        = (state_q == LOCKED);
  assign offset        = offset_q;
`ifdef ALIGN_STATS_EN
  assign relock_cnt    = relock_q;
`endif

endmodule

// File: tb/tb_comma_word_aligner.sv
// Bench for comma_word_aligner: serial bit-stream generator with controllable
// slip, and a reference model working on whole words with shift arithmetic.
module tb_comma_word_aligner;

  localparam int         LOCK_CNT   = 3;
  localparam int         UNLOCK_CNT = 4;
  localparam logic [9:0] CN = 10'b0011111010;
  localparam logic [9:0] CP = 10'b1100000101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rx_word = 10'd0;
  logic        rx_valid = 1'b0;
  logic [9:0]  aligned_word;
  logic        aligned_valid;
  logic        is_comma;
  logic        locked;
  logic [3:0]  offset;
`ifdef ALIGN_STATS_EN
  logic [15:0] relock_cnt;
`endif

  comma_word_aligner #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_word       (rx_word),
    .rx_valid      (rx_valid),
    .aligned_word  (aligned_word),
    .aligned_valid (aligned_valid),
    .is_comma      (is_comma),
    .locked        (locked),
    .offset        (offset)
`ifdef ALIGN_STATS_EN
    ,
    .relock_cnt    (relock_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [9:0] m_cur;
  int         m_mode;   // 0 hunting, 1 confirming, 2 locked
  int         m_cnt, m_err, m_off, m_relock;
  logic [9:0] m_aw;
  logic       m_av, m_ic;

  task automatic model_reset();
    m_cur = '0; m_mode = 0; m_cnt = 0; m_err = 0; m_off = 0; m_relock = 0;
    m_aw = '0; m_av = 1'b0; m_ic = 1'b0;
  endtask

  task automatic model_step(input logic [9:0] w, input logic v);
    logic [19:0] wn;
    logic [9:0]  c [10];
    bit          h [10];
    int          first;
    if (!v) begin
      m_av = 1'b0;
      return;
    end
    wn = {m_cur, w};
    m_cur = w;
    first = -1;
    for (int k = 9; k >= 0; k--) begin
      c[k] = 10'(wn >> (10 - k));
      h[k] = (c[k] == CN) || (c[k] == CP);
      if (h[k]) first = k;
    end
    if (m_mode == 2) begin
      m_aw = c[m_off]; m_av = 1'b1; m_ic = (c[m_off] == CN) || (c[m_off] == CP);
    end else begin
      m_av = 1'b0;
    end
    if (m_mode == 0) begin
      if (first >= 0) begin
        m_off = first; m_cnt = 1;
        if (LOCK_CNT == 1) begin m_mode = 2; m_err = 0; end else m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (h[m_off]) begin
        m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        if (m_cnt >= LOCK_CNT) begin m_mode = 2; m_err = 0; end
      end else if (first >= 0) begin
        m_off = first; m_cnt = 1;
      end
    end else begin
      if (h[m_off]) m_err = 0;
      else if (first >= 0) begin
        m_err = (m_err < 15) ? m_err + 1 : 15;
        if (m_err >= UNLOCK_CNT) begin
          m_mode = 0; m_cnt = 0; m_err = 0;
          if (m_relock < 65535) m_relock++;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".aligned_word"},  16'(aligned_word),  16'(m_aw));
    chk({tag, ".aligned_valid"}, 16'(aligned_valid), 16'(m_av));
    chk({tag, ".is_comma"},      16'(is_comma),      16'(m_ic));
    chk({tag, ".locked"},        16'(locked),        16'(m_mode == 2));
    chk({tag, ".offset"},        16'(offset),        16'(m_off));
`ifdef ALIGN_STATS_EN
    chk({tag, ".relock_cnt"},    relock_cnt,         16'(m_relock));
`endif
  endtask

  // ---------------- stimulus helpers ----------------
  bit bq[$];
  int tot_bits = 0;
  bit gap_en = 1'b0;

  task automatic step(input logic [9:0] w, input logic v);
    rx_word = w; rx_valid = v;
    @(posedge clk);
    if (rst) model_reset(); else model_step(w, v);
    #1;
    check_all("beat");
  endtask

  function automatic logic [9:0] pop_word();
    logic [9:0] w;
    for (int i = 9; i >= 0; i--) w[i] = bq.pop_front();
    return w;
  endfunction

  function automatic logic [9:0] rand_fill();
    return ($urandom_range(0, 1) == 1) ? 10'h2AA : 10'h155;
  endfunction

  task automatic push_sym(input logic [9:0] s);
    for (int i = 9; i >= 0; i--) bq.push_back(s[i]);
    tot_bits += 10;
  endtask

  // Junk bits alternate starting with 1 so they never build a comma run.
  task automatic align_to(input int k);
    int n;
    n = (k - (tot_bits % 10) + 10) % 10;
    for (int i = 0; i < n; i++) bq.push_back(((i % 2) == 0) ? 1'b1 : 1'b0);
    tot_bits += n;
  endtask

  task automatic drain();
    logic [9:0] w;
    while (bq.size() >= 10) begin
      w = pop_word();
      if (gap_en && $urandom_range(0, 4) == 0) step(10'($urandom), 1'b0);
      step(w, 1'b1);
    end
  endtask

  task automatic send(input logic [9:0] s);
    push_sym(s);
    drain();
  endtask

  task automatic comma_then_fill(input int nfill);
    send(CN);
    for (int i = 0; i < nfill; i++) send(rand_fill());
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    bq.delete();
    tot_bits = 0;
  endtask

  // ---------------- directed sequence ----------------
  logic [9:0] syms[$];
  logic [9:0] w2;

  initial begin
    model_reset();
    // Reset held with random traffic: everything stays zero.
    for (int i = 0; i < 6; i++) step(10'($urandom), 1'($urandom));
    rst = 1'b0;

    // Comma every 4 symbols at slip 3; lock on the third, symbols come out in order.
    align_to(3);
    for (int j = 0; j < 16; j++) begin
      w2 = ((j % 4) == 0) ? CN : rand_fill();
      syms.push_back(w2);
      push_sym(w2);
    end
    for (int n = 0; bq.size() >= 10; n++) begin
      step(pop_word(), 1'b1);
      if (n == 8) chk("t2_not_yet_locked", 16'(locked), 16'd0);
      if (n == 9) begin
        chk("t2_locked", 16'(locked), 16'd1);
        chk("t2_offset", 16'(offset), 16'd3);
      end
      if (n >= 10) begin
        chk("t2_valid", 16'(aligned_valid), 16'd1);
        chk("t2_symbol", 16'(aligned_word), 16'(syms[n-1]));
        chk("t2_is_comma", 16'(is_comma), 16'(syms[n-1] == CN));
      end
    end

    // Confirming at 3 with two commas, then a comma at 5 restarts the count.
    pulse_rst();
    align_to(3);
    comma_then_fill(3);
    comma_then_fill(3);
    chk("t3_cnt2_unlocked", 16'(locked), 16'd0);
    chk("t3_cnt2_offset", 16'(offset), 16'd3);
    align_to(5);
    comma_then_fill(2);
    chk("t3_restart_offset", 16'(offset), 16'd5);
    chk("t3_restart_unlocked", 16'(locked), 16'd0);
    send(rand_fill());
    comma_then_fill(3);
    chk("t3_one_more_unlocked", 16'(locked), 16'd0);
    comma_then_fill(2);
    chk("t3_relocked", 16'(locked), 16'd1);
    chk("t3_relock_offset", 16'(offset), 16'd5);

    // Misaligned commas while locked; a good one in between clears the errors.
    align_to(7);
    for (int i = 0; i < 3; i++) comma_then_fill(3);
    chk("t4_three_bad_hold", 16'(locked), 16'd1);
    align_to(5);
    comma_then_fill(3);
    align_to(7);
    for (int i = 0; i < 3; i++) comma_then_fill(3);
    chk("t4_err_reset_hold", 16'(locked), 16'd1);
    comma_then_fill(2);
    chk("t4_lock_lost", 16'(locked), 16'd0);
`ifdef ALIGN_STATS_EN
    chk("t4_relock_cnt", relock_cnt, 16'd1);
`endif

    // Relock at 3, then a valid gap pattern 1-0-0-1.
    align_to(3);
    for (int i = 0; i < 3; i++) comma_then_fill(3);
    chk("t5_locked", 16'(locked), 16'd1);
    chk("t5_offset", 16'(offset), 16'd3);
    for (int i = 0; i < 3; i++) push_sym(rand_fill());
    step(pop_word(), 1'b1);       chk("t5_av_1a", 16'(aligned_valid), 16'd1);
    step(10'($urandom), 1'b0);    chk("t5_av_0a", 16'(aligned_valid), 16'd0);
    step(10'($urandom), 1'b0);    chk("t5_av_0b", 16'(aligned_valid), 16'd0);
    step(pop_word(), 1'b1);       chk("t5_av_1b", 16'(aligned_valid), 16'd1);
    drain();

    // Reset while locked: immediate clear, then exactly LOCK_CNT fresh commas.
    pulse_rst();
    chk("t6_after_rst_locked", 16'(locked), 16'd0);
    align_to(3);
    comma_then_fill(3);
    comma_then_fill(3);
    chk("t6_two_commas_unlocked", 16'(locked), 16'd0);
    comma_then_fill(2);
    chk("t6_relocked", 16'(locked), 16'd1);
    chk("t6_offset", 16'(offset), 16'd3);

    // Randomized traffic: slips, both disparities, valid gaps.
    gap_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 11) == 0) align_to(int'($urandom_range(0, 9)));
      case ($urandom_range(0, 5))
        0, 1:    send(CN);
        2:       send(CP);
        default: send(rand_fill());
      endcase
    end
    gap_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
